// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scanner_pkg
// Shared definitions for the 4x4 keypad scanner: FSM state encoding, the
// column strobe start value, the all-released row pattern, and two helpers
// for locating a low bit and rotating the active-low column strobe.
// -----------------------------------------------------------------------------
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] COL_INIT = 4'b1110;
    localparam logic [3:0] KEY_IDLE = 4'b1111;

    // Index of the lowest zero bit; returns 0 when no bit is low.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else if (!v[3]) idx = 2'd3;
        else            idx = 2'd0;
        return idx;
    endfunction

    // Move the single low bit one position up, wrapping 0111 -> 1110.
    function automatic logic [3:0] rotate_col(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running divider producing a one-cycle tick every 2^SCAN_DIV_W cycles.
// Shared by the keypad scanner and the display scanner.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (divider returns to 0)
//   tick - high for one cycle whenever the divider is all-ones
// -----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int SCAN_DIV_W = 12
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [SCAN_DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + SCAN_DIV_W'(1);
        end
    end

    assign tick = &r_div;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Drives a 4x4 matrix keypad with a rotating active-low column strobe, reads
// the active-low rows through a 2-flop synchronizer, debounces press and
// release on scan ticks, and emits one hex code per accepted press. Codes
// are folded into a 32-bit value register.
//
// Build option: KEYPAD_ACC_EN
//   defined   - each accepted code shifts into value from the bottom
//   undefined - value holds only the most recent code
//
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   row_n     - keypad rows, active-low, asynchronous to clk
//   col_n     - column strobe, active-low, exactly one bit low
//   clr       - single-cycle clear of value (wins over a same-cycle key)
//   key_valid - one-cycle pulse per accepted press
//   key_code  - last accepted key, row*4 + col
//   key_down  - high from acceptance until release is confirmed
//   value     - accumulated digits
//   dbg_state - current FSM state
//
// Handshake: key_valid is a strobe with no back-pressure; key_code is valid
// in the key_valid cycle and holds until the next accepted press.
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV_W   = 12,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic [31:0] value,
    output state_t      dbg_state
);

    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CNT);

    logic        w_tick;

    logic [3:0]  r_sync1;
    logic [3:0]  r_rows_s;
    state_t      r_state;
    logic [3:0]  r_col_n;
    logic [1:0]  r_row;
    logic [3:0]  r_cnt;
    logic [3:0]  r_rcnt;
    logic        r_valid;
    logic [3:0]  r_code;
    logic        r_down;
    logic [31:0] r_value;

    state_t      w_state_nxt;
    logic [3:0]  w_col_nxt;
    logic [1:0]  w_row_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  w_rcnt_nxt;
    logic        w_valid_nxt;
    logic [3:0]  w_code_nxt;
    logic        w_down_nxt;
    logic [31:0] w_value_nxt;
    logic [1:0]  w_col_idx;

    scan_tick_gen #(
        .SCAN_DIV_W (SCAN_DIV_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= KEY_IDLE;
            r_rows_s <= KEY_IDLE;
            r_state  <= SCAN;
            r_col_n  <= COL_INIT;
            r_row    <= 2'd0;
            r_cnt    <= 4'd0;
            r_rcnt   <= 4'd0;
            r_valid  <= 1'b0;
            r_code   <= 4'd0;
            r_down   <= 1'b0;
            r_value  <= 32'd0;
        end else begin
            r_sync1  <= row_n;
            r_rows_s <= r_sync1;
            r_state  <= w_state_nxt;
            r_col_n  <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_valid  <= w_valid_nxt;
            r_code   <= w_code_nxt;
            r_down   <= w_down_nxt;
            r_value  <= w_value_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_n;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        w_rcnt_nxt  = r_rcnt;
        w_valid_nxt = 1'b0;
        w_code_nxt  = r_code;
        w_down_nxt  = r_down;
        w_col_idx   = low_index(r_col_n);

        case (r_state)
            SCAN: begin
                if (w_tick) begin
                    if (r_rows_s == KEY_IDLE) begin
                        w_col_nxt = rotate_col(r_col_n);
                    end else begin
                        w_row_nxt   = low_index(r_rows_s);
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                // Acceptance is taken the cycle after the count is reached,
                // independent of tick, so key_valid lands one cycle later.
                if (r_cnt == DB_MAX) begin
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = {r_row, w_col_idx};
                    w_down_nxt  = 1'b1;
                    w_rcnt_nxt  = 4'd0;
                    w_state_nxt = HELD;
                end else if (w_tick) begin
                    if (!r_rows_s[r_row]) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else begin
                        w_col_nxt   = rotate_col(r_col_n);
                        w_state_nxt = SCAN;
                    end
                end
            end
            HELD: begin
                // Any low row in the frozen column restarts the release count,
                // so a second key only delays release and never re-triggers.
                if (r_rcnt == DB_MAX) begin
                    w_down_nxt  = 1'b0;
                    w_col_nxt   = rotate_col(r_col_n);
                    w_state_nxt = SCAN;
                end else if (w_tick) begin
                    if (r_rows_s == KEY_IDLE) begin
                        w_rcnt_nxt = r_rcnt + 4'd1;
                    end else begin
                        w_rcnt_nxt = 4'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = SCAN;
                w_col_nxt   = COL_INIT;
            end
        endcase

        if (clr) begin
            w_value_nxt = 32'd0;
        end else if (r_valid) begin
`ifdef KEYPAD_ACC_EN
            w_value_nxt = {r_value[27:0], r_code};
`else
            w_value_nxt = {28'd0, r_code};
`endif
        end else begin
            w_value_nxt = r_value;
        end
    end

    assign col_n     = r_col_n;
    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign key_down  = r_down;
    assign value     = r_value;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Bench for keypad_scanner with SCAN_DIV_W=2, DEBOUNCE_CNT=3. A physical
// keypad model connects pressed keys between their row and column.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [31:0] value;
    state_t      dbg_state;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    logic [31:0] exp_value;
    int          n_checks;
    int          n_fail;
    int          n_valid;
    logic        prev_valid;

    keypad_scanner #(
        .SCAN_DIV_W   (2),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down),
        .value     (value),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key k = row*4+col pulls row low while its column is strobed.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard / monitor
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("col_onehot", 32'($countones(~col_n)), 32'd1);
            if (key_valid) begin
                n_valid++;
                check_eq("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
                check_eq("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
                end
            end
        end
        prev_valid = key_valid;
    end

    function automatic logic [31:0] model_value(input logic [31:0] v, input logic [3:0] code);
`ifdef KEYPAD_ACC_EN
        return (v << 4) | {28'd0, code};
`else
        return {28'd0, code};
`endif
    endfunction

    // Driver: press a set of keys, expect one code, hold, release.
    task automatic press_mask(input logic [15:0] mask, input logic [3:0] code, input int hold);
        int  start;
        bit  got;
        int  rel;
        exp_q.push_back(code);
        start   = n_valid;
        pressed = mask;
        got     = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk); #1;
            if (n_valid != start) begin
                got = 1;
                break;
            end
        end
        check_eq("press_valid_seen", {31'd0, got}, 32'd1);
        check_eq("key_down_on_press", {31'd0, key_down}, 32'd1);
        repeat (hold) @(negedge clk);
        #1;
        check_eq("key_down_held", {31'd0, key_down}, 32'd1);
        pressed = 16'd0;
        rel = 0;
        while (key_down && rel < 60) begin
            @(negedge clk); #1;
            rel++;
        end
        check_eq("key_down_release", {31'd0, key_down}, 32'd0);
        check_eq("release_not_early", {31'd0, rel >= 10}, 32'd1);
        check_eq("release_not_late", {31'd0, rel <= 18}, 32'd1);
        check_eq("one_valid_per_press", 32'(n_valid - start), 32'd1);
        exp_value = model_value(exp_value, code);
        check_eq("value", value, exp_value);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk); #1;
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
        exp_value = 32'd0;
        @(negedge clk); #1;
        check_eq("clr_value", value, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_col;
        logic [3:0] code;
        int         changes;
        int         bad;
        int         last;
        int         start;
        bit         got;
        int         k;

        n_checks   = 0;
        n_fail     = 0;
        n_valid    = 0;
        prev_valid = 1'b0;
        exp_value  = 32'd0;
        pressed    = 16'd0;
        clr        = 1'b0;
        rst        = 1'b1;

        // 1. Reset and idle rotation
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_col_n", {28'd0, col_n}, 32'hE);
        check_eq("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check_eq("rst_key_code", {28'd0, key_code}, 32'd0);
        check_eq("rst_key_down", {31'd0, key_down}, 32'd0);
        check_eq("rst_value", value, 32'd0);
        rst      = 1'b0;
        prev_col = col_n;
        changes  = 0;
        bad      = 0;
        last     = 0;
        for (int t = 1; t <= 17; t++) begin
            @(negedge clk); #1;
            if (col_n != prev_col) begin
                changes++;
                if (t - last != 4) bad++;
                if (col_n != {prev_col[2:0], prev_col[3]}) bad++;
                last     = t;
                prev_col = col_n;
            end
        end
        check_eq("idle_rotation_steps", 32'(changes), 32'd4);
        check_eq("idle_rotation_order", 32'(bad), 32'd0);
        check_eq("idle_col_back_home", {28'd0, col_n}, 32'hE);
        check_eq("idle_no_valid", 32'(n_valid), 32'd0);

        // 2. Single press: row 2, col 1
        press_mask(16'h0200, 4'h9, 30);
        check_eq("single_value", value, 32'h9);

        // 3. Bounce on key 0 alternating each tick
        start = n_valid;
        for (int i = 0; i < 16; i++) begin
            pressed[0] = ~pressed[0];
            repeat (4) @(negedge clk);
            #1;
        end
        pressed = 16'd0;
        check_eq("bounce_no_valid", 32'(n_valid - start), 32'd0);
        prev_col = col_n;
        changes  = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (col_n != prev_col) changes++;
            prev_col = col_n;
        end
        check_eq("bounce_scan_resumes", {31'd0, changes >= 4}, 32'd1);
        check_eq("bounce_key_down", {31'd0, key_down}, 32'd0);

        // 4. Accumulation of 1..9
        pulse_clr();
        for (int d = 1; d <= 9; d++) begin
            press_mask(16'h0001 << d, 4'(d), 2);
        end
`ifdef KEYPAD_ACC_EN
        check_eq("accum_value", value, 32'h23456789);
`else
        check_eq("accum_value", value, 32'h00000009);
`endif

        // 5a. clr in the same cycle as key_valid for key A
        exp_q.push_back(4'hA);
        start   = n_valid;
        pressed = 16'h0400;
        got     = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk); #1;
            if (key_valid) begin
                got = 1;
                break;
            end
        end
        check_eq("clr_race_valid_seen", {31'd0, got}, 32'd1);
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
        exp_value = 32'd0;
        check_eq("clr_race_value", value, 32'd0);
        check_eq("clr_race_code", {28'd0, key_code}, 32'hA);
        pressed = 16'd0;
        for (int t = 0; t < 60 && key_down; t++) begin
            @(negedge clk); #1;
        end
        check_eq("clr_race_release", {31'd0, key_down}, 32'd0);
        check_eq("clr_race_one_valid", 32'(n_valid - start), 32'd1);
        repeat (4) @(negedge clk);

        // 5b. Rows 1 and 3 low in column 3: lowest row wins
        press_mask(16'h8080, 4'h7, 5);

        // 6. Reset while HELD with the key still pressed
        exp_q.push_back(4'h5);
        start   = n_valid;
        pressed = 16'h0020;
        for (int t = 0; t < 60 && n_valid == start; t++) begin
            @(negedge clk); #1;
        end
        check_eq("midrst_first_valid", 32'(n_valid - start), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check_eq("midrst_held_state", {30'd0, dbg_state}, {30'd0, HELD});
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("midrst_col_n", {28'd0, col_n}, 32'hE);
        check_eq("midrst_key_down", {31'd0, key_down}, 32'd0);
        check_eq("midrst_value", value, 32'd0);
        check_eq("midrst_key_valid", {31'd0, key_valid}, 32'd0);
        rst       = 1'b0;
        exp_value = 32'd0;
        press_mask(16'h0020, 4'h5, 3);
        check_eq("midrst_two_valids", 32'(n_valid - start), 32'd2);

        // Randomized presses with occasional clears
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 3) == 0) pulse_clr();
            k    = $urandom_range(0, 15);
            code = 4'(k);
            press_mask(16'h0001 << k, code, $urandom_range(0, 20));
        end

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
